// File: rtl/idu_stage.sv
// idu_stage: registered RV32I/M instruction-decode stage.
//
// Decodes in_inst combinationally and captures the results into a single
// output register stage. A valid/ready handshake connects it to fetch and execute.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           drop the held beat and any incoming beat
//   in_valid/ready  upstream handshake; in_inst / in_pc carry the beat
//   out_valid/ready downstream handshake
//   out_opc         opcode index (0 = illegal)
//   out_rd/rs1/rs2  register indices, 0 when the format does not use them
//   out_imm         sign-extended immediate (zero-extended shamt for shifts)
//   out_pc          registered in_pc
//   out_illegal     encoding not recognised
//   out_ebreak      system instruction is ebreak
module idu_stage #(
    parameter int XLEN      = 32,
    parameter bit EN_M      = 1'b1,
    parameter int NR_INST   = 46,
    parameter int OPC_WIDTH = $clog2(NR_INST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPC_WIDTH-1:0] out_opc,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_illegal,
    output logic                 out_ebreak
);

    // Immediate/field format classes selected by the major opcode.
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_R    = 3'd1;
    localparam logic [2:0] FMT_I    = 3'd2;
    localparam logic [2:0] FMT_SH   = 3'd3;
    localparam logic [2:0] FMT_S    = 3'd4;
    localparam logic [2:0] FMT_B    = 3'd5;
    localparam logic [2:0] FMT_U    = 3'd6;
    localparam logic [2:0] FMT_J    = 3'd7;

    localparam logic [OPC_WIDTH-1:0] OPC_SYSTEM = OPC_WIDTH'(38);

    // Sign-extend a 32-bit immediate to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]           opcode_s;
    logic [2:0]           funct3_s;
    logic [6:0]           funct7_s;
    logic [OPC_WIDTH-1:0] opc_s;
    logic [2:0]           fmt_s;
    logic                 illegal_s;
    logic [4:0]           rd_s, rs1_s, rs2_s;
    logic [XLEN-1:0]      imm_s;
    logic                 ebreak_s;
    logic                 accept_s;

    logic                 valid_r;
    logic [OPC_WIDTH-1:0] opc_r;
    logic [4:0]           rd_r, rs1_r, rs2_r;
    logic [XLEN-1:0]      imm_r, pc_r;
    logic                 illegal_r, ebreak_r;

    assign opcode_s = in_inst[6:0];
    assign funct3_s = in_inst[14:12];
    assign funct7_s = in_inst[31:25];

    // Opcode index and format class. The full 7-bit opcode is matched, so
    // any encoding with inst[1:0] != 2'b11 falls through to illegal.
    always_comb begin
        opc_s = '0;
        fmt_s = FMT_NONE;
        case (opcode_s)
            7'h33: begin
                fmt_s = FMT_R;
                if (funct7_s == 7'h00) begin
                    case (funct3_s)
                        3'd0:    opc_s = OPC_WIDTH'(1);
                        3'd1:    opc_s = OPC_WIDTH'(6);
                        3'd2:    opc_s = OPC_WIDTH'(9);
                        3'd3:    opc_s = OPC_WIDTH'(10);
                        3'd4:    opc_s = OPC_WIDTH'(3);
                        3'd5:    opc_s = OPC_WIDTH'(7);
                        3'd6:    opc_s = OPC_WIDTH'(4);
                        default: opc_s = OPC_WIDTH'(5);
                    endcase
                end else if (funct7_s == 7'h20) begin
                    if (funct3_s == 3'd0) begin
                        opc_s = OPC_WIDTH'(2);
                    end else if (funct3_s == 3'd5) begin
                        opc_s = OPC_WIDTH'(8);
                    end else begin
                        opc_s = '0;
                    end
                end else if (EN_M && (funct7_s == 7'h01)) begin
                    // mul..remu are numbered in funct3 order from 39.
                    opc_s = OPC_WIDTH'(7'd39 + {4'd0, funct3_s});
                end else begin
                    opc_s = '0;
                end
            end
            7'h13: begin
                fmt_s = FMT_I;
                case (funct3_s)
                    3'd0: opc_s = OPC_WIDTH'(11);
                    3'd2: opc_s = OPC_WIDTH'(18);
                    3'd3: opc_s = OPC_WIDTH'(19);
                    3'd4: opc_s = OPC_WIDTH'(12);
                    3'd6: opc_s = OPC_WIDTH'(13);
                    3'd7: opc_s = OPC_WIDTH'(14);
                    3'd1: begin
                        fmt_s = FMT_SH;
                        opc_s = (funct7_s == 7'h00) ? OPC_WIDTH'(15) : '0;
                    end
                    default: begin
                        fmt_s = FMT_SH;
                        if (funct7_s == 7'h00) begin
                            opc_s = OPC_WIDTH'(16);
                        end else if (funct7_s == 7'h20) begin
                            opc_s = OPC_WIDTH'(17);
                        end else begin
                            opc_s = '0;
                        end
                    end
                endcase
            end
            7'h03: begin
                fmt_s = FMT_I;
                case (funct3_s)
                    3'd0:    opc_s = OPC_WIDTH'(20);
                    3'd1:    opc_s = OPC_WIDTH'(21);
                    3'd2:    opc_s = OPC_WIDTH'(22);
                    3'd4:    opc_s = OPC_WIDTH'(23);
                    3'd5:    opc_s = OPC_WIDTH'(24);
                    default: opc_s = '0;
                endcase
            end
            7'h23: begin
                fmt_s = FMT_S;
                case (funct3_s)
                    3'd0:    opc_s = OPC_WIDTH'(25);
                    3'd1:    opc_s = OPC_WIDTH'(26);
                    3'd2:    opc_s = OPC_WIDTH'(27);
                    default: opc_s = '0;
                endcase
            end
            7'h63: begin
                fmt_s = FMT_B;
                case (funct3_s)
                    3'd0:    opc_s = OPC_WIDTH'(28);
                    3'd1:    opc_s = OPC_WIDTH'(29);
                    3'd4:    opc_s = OPC_WIDTH'(30);
                    3'd5:    opc_s = OPC_WIDTH'(31);
                    3'd6:    opc_s = OPC_WIDTH'(32);
                    3'd7:    opc_s = OPC_WIDTH'(33);
                    default: opc_s = '0;
                endcase
            end
            7'h6F: begin
                fmt_s = FMT_J;
                opc_s = OPC_WIDTH'(34);
            end
            7'h67: begin
                fmt_s = FMT_I;
                opc_s = (funct3_s == 3'd0) ? OPC_WIDTH'(35) : '0;
            end
            7'h37: begin
                fmt_s = FMT_U;
                opc_s = OPC_WIDTH'(36);
            end
            7'h17: begin
                fmt_s = FMT_U;
                opc_s = OPC_WIDTH'(37);
            end
            7'h73: begin
                // Only ecall (imm 0) and ebreak (imm 1) with zero rd/rs1/funct3.
                fmt_s = FMT_I;
                if ((funct3_s == 3'd0) && (in_inst[11:7] == 5'd0) &&
                    (in_inst[19:15] == 5'd0) && (in_inst[31:21] == 11'd0)) begin
                    opc_s = OPC_SYSTEM;
                end else begin
                    opc_s = '0;
                end
            end
            default: begin
                fmt_s = FMT_NONE;
                opc_s = '0;
            end
        endcase
    end

    assign illegal_s = (opc_s == '0);

    // Register indices and immediate by format; all zero for illegal beats.
    always_comb begin
        rd_s  = 5'd0;
        rs1_s = 5'd0;
        rs2_s = 5'd0;
        imm_s = '0;
        if (illegal_s) begin
            rd_s  = 5'd0;
        end else begin
            case (fmt_s)
                FMT_R: begin
                    rd_s  = in_inst[11:7];
                    rs1_s = in_inst[19:15];
                    rs2_s = in_inst[24:20];
                end
                FMT_I: begin
                    rd_s  = in_inst[11:7];
                    rs1_s = in_inst[19:15];
                    imm_s = sext32({{20{in_inst[31]}}, in_inst[31:20]});
                end
                FMT_SH: begin
                    rd_s  = in_inst[11:7];
                    rs1_s = in_inst[19:15];
                    imm_s = XLEN'(in_inst[24:20]);
                end
                FMT_S: begin
                    rs1_s = in_inst[19:15];
                    rs2_s = in_inst[24:20];
                    imm_s = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
                end
                FMT_B: begin
                    rs1_s = in_inst[19:15];
                    rs2_s = in_inst[24:20];
                    imm_s = sext32({{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                                    in_inst[11:8], 1'b0});
                end
                FMT_U: begin
                    rd_s  = in_inst[11:7];
                    imm_s = sext32({in_inst[31:12], 12'd0});
                end
                FMT_J: begin
                    rd_s  = in_inst[11:7];
                    imm_s = sext32({{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                                    in_inst[30:21], 1'b0});
                end
                default: begin
                    rd_s  = 5'd0;
                end
            endcase
        end
    end

    assign ebreak_s = (opc_s == OPC_SYSTEM) && in_inst[20];

    assign in_ready = !valid_r || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // Valid flag: reset > flush > accept > retire > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data registers load only on accept, so they are frozen during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_r     <= '0;
            rd_r      <= 5'd0;
            rs1_r     <= 5'd0;
            rs2_r     <= 5'd0;
            imm_r     <= '0;
            pc_r      <= '0;
            illegal_r <= 1'b0;
            ebreak_r  <= 1'b0;
        end else if (accept_s) begin
            opc_r     <= opc_s;
            rd_r      <= rd_s;
            rs1_r     <= rs1_s;
            rs2_r     <= rs2_s;
            imm_r     <= imm_s;
            pc_r      <= in_pc;
            illegal_r <= illegal_s;
            ebreak_r  <= ebreak_s;
        end else begin
            opc_r     <= opc_r;
        end
    end

    assign out_valid   = valid_r;
    assign out_opc     = opc_r;
    assign out_rd      = rd_r;
    assign out_rs1     = rs1_r;
    assign out_rs2     = rs2_r;
    assign out_imm     = imm_r;
    assign out_pc      = pc_r;
    assign out_illegal = illegal_r;
    assign out_ebreak  = ebreak_r;

endmodule

// File: tb/tb_idu_stage.sv
// Directed testbench for idu_stage: one EN_M=1 instance and one EN_M=0
// instance share all inputs; expected values are hand-decoded constants.
module tb_idu_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid, out_illegal, out_ebreak;
    logic [5:0]  out_opc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc;

    logic        m0_in_ready, m0_valid, m0_illegal, m0_ebreak;
    logic [5:0]  m0_opc;
    logic [4:0]  m0_rd, m0_rs1, m0_rs2;
    logic [31:0] m0_imm, m0_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        ill, ebr;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    idu_stage #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_opc(out_opc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal), .out_ebreak(out_ebreak)
    );

    idu_stage #(.XLEN(32), .EN_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(m0_valid), .out_ready(out_ready),
        .out_opc(m0_opc), .out_rd(m0_rd), .out_rs1(m0_rs1), .out_rs2(m0_rs2),
        .out_imm(m0_imm), .out_pc(m0_pc), .out_illegal(m0_illegal), .out_ebreak(m0_ebreak)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; in_pc = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if ({out_opc, out_rd, out_rs1, out_rs2} !== 21'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {out_opc, out_rd, out_rs1, out_rs2}); end
        checks++; if ({out_imm, out_pc} !== 64'd0) begin errors++; $display("FAIL reset_imm_pc got %h want 0", {out_imm, out_pc}); end
        checks++; if ({out_illegal, out_ebreak} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {out_illegal, out_ebreak}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h0000_0100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", out_valid); end
        checks++; if (out_opc !== 6'd1) begin errors++; $display("FAIL add_opc got %0d want 1", out_opc); end
        checks++; if ({out_rd, out_rs1, out_rs2} !== {5'd3, 5'd1, 5'd2}) begin errors++; $display("FAIL add_regs got %0d/%0d/%0d want 3/1/2", out_rd, out_rs1, out_rs2); end
        checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL add_imm got %h want 0", out_imm); end
        checks++; if (out_pc !== 32'h0000_0100) begin errors++; $display("FAIL add_pc got %h want 100", out_pc); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_retire got %b want 0", out_valid); end
    endtask

    task automatic test_decode();
        vecs[0]  = '{32'hFFF00093, 6'd11, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0}; // addi x1,x0,-1
        vecs[1]  = '{32'hFE000EE3, 6'd28, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0}; // beq -4
        vecs[2]  = '{32'h00100073, 6'd38, 5'd0, 5'd0, 5'd0, 32'h00000001, 1'b0, 1'b1}; // ebreak
        vecs[3]  = '{32'h00000073, 6'd38, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}; // ecall
        vecs[4]  = '{32'h00200073, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0}; // bad system
        vecs[5]  = '{32'h4030D093, 6'd17, 5'd1, 5'd1, 5'd0, 32'h00000003, 1'b0, 1'b0}; // srai x1,x1,3
        vecs[6]  = '{32'h40309093, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0}; // slli with f7=0x20
        vecs[7]  = '{32'h0020A423, 6'd27, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b0, 1'b0}; // sw x2,8(x1)
        vecs[8]  = '{32'h123452B7, 6'd36, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0}; // lui x5
        vecs[9]  = '{32'hFFFFF06F, 6'd34, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0}; // jal x0,-2
        vecs[10] = '{32'h000090E7, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0}; // jalr funct3=1
        vecs[11] = '{32'h002081B0, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0}; // inst[1:0]=00
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 32'h1000 + 32'(i * 4);
            step();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_valid got %b want 1", i, out_valid); end
            checks++; if (out_opc !== vecs[i].opc) begin errors++; $display("FAIL dec%0d_opc got %0d want %0d", i, out_opc, vecs[i].opc); end
            checks++; if ({out_rd, out_rs1, out_rs2} !== {vecs[i].rd, vecs[i].rs1, vecs[i].rs2}) begin errors++; $display("FAIL dec%0d_regs got %0d/%0d/%0d want %0d/%0d/%0d", i, out_rd, out_rs1, out_rs2, vecs[i].rd, vecs[i].rs1, vecs[i].rs2); end
            checks++; if (out_imm !== vecs[i].imm) begin errors++; $display("FAIL dec%0d_imm got %h want %h", i, out_imm, vecs[i].imm); end
            checks++; if ({out_illegal, out_ebreak} !== {vecs[i].ill, vecs[i].ebr}) begin errors++; $display("FAIL dec%0d_flags got %b want %b", i, {out_illegal, out_ebreak}, {vecs[i].ill, vecs[i].ebr}); end
        end
        step();
    endtask

    task automatic test_mext();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h022081B3; in_pc = 32'h2000;
        step();
        in_valid = 1'b0;
        checks++; if (out_opc !== 6'd39) begin errors++; $display("FAIL mul_opc got %0d want 39", out_opc); end
        checks++; if ({out_rd, out_rs1, out_rs2, out_illegal} !== {5'd3, 5'd1, 5'd2, 1'b0}) begin errors++; $display("FAIL mul_regs got %h want 3/1/2 legal", {out_rd, out_rs1, out_rs2, out_illegal}); end
        checks++; if ({m0_valid, m0_opc, m0_illegal} !== {1'b1, 6'd0, 1'b1}) begin errors++; $display("FAIL mul_nom got v=%b opc=%0d ill=%b want v=1 opc=0 ill=1", m0_valid, m0_opc, m0_illegal); end
        checks++; if ({m0_rd, m0_rs1, m0_rs2, m0_imm} !== 47'd0) begin errors++; $display("FAIL mul_nom_fields got %h want 0", {m0_rd, m0_rs1, m0_rs2, m0_imm}); end
        in_valid = 1'b1; in_inst = 32'h0220F1B3; in_pc = 32'h2004; // remu x3,x1,x2
        step();
        in_valid = 1'b0;
        checks++; if (out_opc !== 6'd46) begin errors++; $display("FAIL remu_opc got %0d want 46", out_opc); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4];
        logic [31:0] insts [4];
        for (int i = 0; i < 4; i++) begin
            pcs[i]   = 32'h3000 + 32'(i * 4);
            insts[i] = 32'h00100013 | (32'(i + 1) << 7); // addi x(i+1),x0,1
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = insts[0]; in_pc = pcs[0];
        step();
        out_ready = 1'b0; in_inst = insts[1]; in_pc = pcs[1];
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready got %b want 0", c, in_ready); end
            checks++; if ({out_valid, out_pc, out_rd} !== {1'b1, pcs[0], 5'd1}) begin errors++; $display("FAIL stall%0d_hold got v=%b pc=%h rd=%0d want v=1 pc=%h rd=1", c, out_valid, out_pc, out_rd, pcs[0]); end
            step();
        end
        checks++; if ({out_valid, out_pc, out_rd, out_opc} !== {1'b1, pcs[0], 5'd1, 6'd11}) begin errors++; $display("FAIL stall_end got pc=%h rd=%0d want pc=%h rd=1", out_pc, out_rd, pcs[0]); end
        out_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            in_valid = 1'b1; in_inst = insts[b]; in_pc = pcs[b];
            step();
            checks++; if ({out_valid, out_pc, out_rd} !== {1'b1, pcs[b], 5'(b + 1)}) begin errors++; $display("FAIL b2b%0d got v=%b pc=%h rd=%0d want v=1 pc=%h rd=%0d", b, out_valid, out_pc, out_rd, pcs[b], b + 1); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h4000;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got %b want 1", out_valid); end
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h4004; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b want 0", out_valid); end
    endtask

    task automatic test_rst_inflight();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'h5000;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got %b want 1", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if ({out_valid, out_opc, out_rd, out_rs1, out_rs2, out_illegal, out_ebreak} !== 24'd0) begin errors++; $display("FAIL rst_ctrl got %h want 0", {out_valid, out_opc, out_rd, out_rs1, out_rs2, out_illegal, out_ebreak}); end
        checks++; if ({out_imm, out_pc} !== 64'd0) begin errors++; $display("FAIL rst_data got %h want 0", {out_imm, out_pc}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode();
        test_mext();
        test_back_to_back();
        test_flush();
        test_rst_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idu_stage.md
# idu_stage

Registered, parametrised RV32I/M instruction-decode stage, the successor to the combinational decoder. It classifies a 32-bit instruction into a one-hot-free opcode index and extracts the register indices and the sign-extended immediate. It also flags illegal encodings, with the M extension optional. It sits between fetch and execute behind a valid/ready handshake, with one register stage, a flush input, and full throughput under back-pressure.

## Interface
- `XLEN`, 32: width of PC and immediate outputs; must be ≥ 32. Immediates are sign-extended to XLEN.
- `EN_M`, 1: 1 decodes mul..remu; 0 makes them illegal.
- `NR_INST`, 46: number of opcode indices.
- `OPC_WIDTH`, `$clog2(NR_INST+1)` = 6: opc width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard the held and the incoming instruction.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  decoded result is held.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_opc`  out  OPC_WIDTH  opcode index; 0 means illegal.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices; 0 when the format does not use the field.
- `out_imm`  out  XLEN  sign-extended immediate; 0 for R-type.
- `out_pc`  out  XLEN  registered in_pc.
- `out_illegal`  out  1  encoding not recognised.
- `out_ebreak`  out  1  system instruction is ebreak (opc 38).

## Operation
- Opc index map:
  - R-type ALU: 1 add, 2 sub, 3 xor, 4 or, 5 and, 6 sll, 7 srl, 8 sra, 9 slt, 10 sltu.
  - I-type ALU: 11 addi, 12 xori, 13 ori, 14 andi, 15 slli, 16 srli, 17 srai, 18 slti, 19 sltiu.
  - Loads: 20 lb, 21 lh, 22 lw, 23 lbu, 24 lhu.
  - Stores: 25 sb, 26 sh, 27 sw.
  - Branches: 28 beq, 29 bne, 30 blt, 31 bge, 32 bltu, 33 bgeu.
  - Jumps and upper-immediate: 34 jal, 35 jalr, 36 lui, 37 auipc.
  - System: 38 ecall/ebreak.
  - M extension: 39 mul, 40 mulh, 41 mulhsu, 42 mulhu, 43 div, 44 divu, 45 rem, 46 remu.
- Match rules:
  - opcode, funct3 and funct7 are compared exactly where the format defines them.
  - Shift-immediates require inst[31:25] = 0x00, or 0x20 for srai.
  - jalr requires funct3 = 0.
  - System instructions require funct3 = 0, rd = 0, rs1 = 0 and inst[31:20] ∈ {0, 1}.
  - inst[1:0] ≠ 2'b11 is illegal.
- Illegal encodings give opc = 0, illegal = 1, rd/rs1/rs2/imm = 0 and ebreak = 0. They still travel the handshake as a normal beat.
- With EN_M = 0, funct7 = 0x01 on opcode 0x33 is illegal.
- Immediates, sign-extended from inst[31]:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Shift-immediate: zero-extended inst[24:20].
- Field usage:
  - rd is 0 for S and B.
  - rs1 is 0 for U and J.
  - rs2 is 0 for I, U and J.
- Decode is combinational on in_inst. The results are captured into output registers.

## Timing
- Reset: out_valid = 0; opc, rd, rs1, rs2, imm, pc, illegal and ebreak are all 0. in_ready = 1 in the first cycle after reset.
- in_ready = !out_valid || out_ready. This is combinational and independent of in_valid.
- Accept occurs when in_valid && in_ready && !flush. The decoded beat appears on the outputs the next cycle: latency 1.
- Throughput: one beat per cycle while out_ready = 1.
- Hold under stall: when out_valid && !out_ready, every out_* signal stays stable and in_inst is not sampled.
- Retire: on out_valid && out_ready with no new accept, out_valid drops to 0 next cycle. Retire and accept in the same cycle replace the held beat with no bubble.
- Flush: out_valid = 0 next cycle. flush has priority over accept, so the incoming beat is dropped. in_ready is unaffected by flush.
- rst has priority over flush and accept. A beat in flight is lost.
- Data registers may keep stale values while out_valid = 0, except immediately after reset, when they are 0.

## Test plan
- Reset then in_inst = 0x002081B3 (add x3,x1,x2), valid for 1 cycle, out_ready = 1 -> next cycle out_valid = 1, opc = 1, rd = 3, rs1 = 1, rs2 = 2, imm = 0; the cycle after, out_valid = 0.
- 0xFFF00093 (addi x1,x0,-1) -> opc = 11, rd = 1, imm = 0xFFFFFFFF, rs2 = 0. Then 0xFE000EE3 (beq -4) -> opc = 28, imm = 0xFFFFFFFC, rd = 0.
- 0x022081B3 (mul): EN_M = 1 -> opc = 39; EN_M = 0 -> opc = 0, illegal = 1. 0x00100073 -> opc = 38, ebreak = 1. 0x00200073 -> illegal = 1.
- Stream of 4 beats with out_ready low for 3 cycles after beat 1 -> outputs frozen on beat 1, in_ready = 0. On release, beats 2–4 appear on consecutive cycles, in order, with none lost or duplicated.
- flush asserted with out_valid = 1 and in_valid = 1 in the same cycle -> out_valid = 0 next cycle and the incoming beat never appears.
- rst pulsed while out_valid = 1 and out_ready = 0 -> all outputs 0 next cycle and in_ready = 1.
